axis_channel_demux: RTL and testbench

AXIS_CHANNEL_DEMUX -- requirements
Module: axis_channel_demux

---
 rtl/axis_channel_demux.sv | 176 +++++++++++++++++
 tb/tb_axis_channel_demux.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_channel_demux.sv
// axis_channel_demux
//   Routes each of CHANNELS parallel-sample streams to one of
//   OUTPUTS = (1+FUNCTIONS_PER_CHANNEL)*CHANNELS outputs. A per-input
//   destination register selects the output. Beats go through an input
//   register stage and an output register stage. When several inputs pick
//   the same output in one beat, the lowest-indexed input wins.
//   Reconfiguration loads every destination field at once and then discards
//   BLANK_CYCLES input beats before the new mapping takes effect.
//
// Ports
//   clk             : sole clock, rising edge
//   reset_n         : asynchronous active-low reset
//   data_in_data    : CHANNELS x DWIDTH source data
//   data_in_valid   : per-channel valid (no backpressure)
//   data_out_data   : OUTPUTS x DWIDTH routed data, held between beats
//   data_out_valid  : per-output one-cycle beat strobe
//   config_in_data  : field i = bits [SELECT_BITS*i +: SELECT_BITS] = dest of input i
//   config_in_valid : config offered
//   config_in_ready : config accepted on a rising edge where valid && ready
//   collision_count : saturating count of beats lost to routing collisions
//   state_dbg       : FSM state (0 = RUN, 1 = BLANK)
//
// Handshake (config_in): a transfer happens on a rising edge where both
// config_in_valid and config_in_ready are high. The source holds data and
// valid stable until that edge. Ready is low while blanking and until the
// first edge after reset, so an offered config waits and is never merged.
module axis_channel_demux #(
   parameter  int PARALLEL_SAMPLES      = 16,
   parameter  int SAMPLE_WIDTH          = 16,
   parameter  int CHANNELS              = 8,
   parameter  int FUNCTIONS_PER_CHANNEL = 1,
   parameter  int BLANK_CYCLES          = 4,
   localparam int OUTPUTS     = (1 + FUNCTIONS_PER_CHANNEL) * CHANNELS,
   localparam int SELECT_BITS = $clog2(OUTPUTS),
   localparam int DWIDTH      = PARALLEL_SAMPLES * SAMPLE_WIDTH
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic [CHANNELS-1:0][DWIDTH-1:0]   data_in_data,
   input  logic [CHANNELS-1:0]               data_in_valid,
   output logic [OUTPUTS-1:0][DWIDTH-1:0]    data_out_data,
   output logic [OUTPUTS-1:0]                data_out_valid,
   input  logic [CHANNELS*SELECT_BITS-1:0]   config_in_data,
   input  logic                              config_in_valid,
   output logic                              config_in_ready,
   output logic [15:0]                       collision_count,
   output logic                              state_dbg
);

   typedef enum logic {RUN = 1'b0, BLANK = 1'b1} state_t;

   // Destination values at or above this limit discard the beat.
   localparam logic [SELECT_BITS:0] OUT_LIMIT = (SELECT_BITS + 1)'(OUTPUTS);

   state_t                            state, state_next;
   logic [7:0]                        blank_cnt, blank_next;
   logic                              armed;
   logic                              dest_load;
   logic [SELECT_BITS-1:0]            dest [CHANNELS];

   logic [CHANNELS-1:0][DWIDTH-1:0]   s1_data;
   logic [CHANNELS-1:0]               s1_valid;
   logic [SELECT_BITS-1:0]            s1_sel [CHANNELS];

   logic [OUTPUTS-1:0]                win_valid;
   logic [OUTPUTS-1:0][DWIDTH-1:0]    win_data;
   logic [15:0]                       losers;
   logic [16:0]                       coll_sum;

   assign state_dbg = state;

   // ------------------------------------------------------------------
   // Configuration FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= RUN;
         blank_cnt <= 8'd0;
         armed     <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) dest[i] <= SELECT_BITS'(i);
      end else begin
         state     <= state_next;
         blank_cnt <= blank_next;
         // Ready stays low until the first edge after reset release.
         armed     <= 1'b1;
         if (dest_load) begin
            for (int i = 0; i < CHANNELS; i++)
               dest[i] <= config_in_data[SELECT_BITS*i +: SELECT_BITS];
         end
      end
   end

   always_comb begin
      state_next      = state;
      blank_next      = blank_cnt;
      dest_load       = 1'b0;
      config_in_ready = 1'b0;
      case (state)
         RUN: begin
            config_in_ready = armed;
            if (config_in_valid && armed) begin
               dest_load  = 1'b1;
               blank_next = 8'(BLANK_CYCLES);
               state_next = BLANK;
            end
         end
         BLANK: begin
            if (blank_cnt <= 8'd1) begin
               blank_next = 8'd0;
               state_next = RUN;
            end else begin
               blank_next = blank_cnt - 8'd1;
            end
         end
         default: state_next = RUN;
      endcase
   end

   // ------------------------------------------------------------------
   // Input register stage. The destination is captured with the beat, so
   // a beat sampled on the reconfiguration edge keeps the old mapping and
   // beats already in flight are unaffected by later loads.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_data  <= '0;
         s1_valid <= '0;
         for (int i = 0; i < CHANNELS; i++) s1_sel[i] <= '0;
      end else begin
         s1_data <= data_in_data;
         for (int i = 0; i < CHANNELS; i++) begin
            s1_sel[i] <= dest[i];
            // Only a definite 1 routes; X or 0 falls to the else branch.
            if ((state == RUN) && data_in_valid[i]) s1_valid[i] <= 1'b1;
            else                                    s1_valid[i] <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Routing with lowest-index priority; every later claimant of an
   // already-taken output is a collision loser.
   // ------------------------------------------------------------------
   always_comb begin
      win_valid = '0;
      win_data  = data_out_data;
      losers    = 16'd0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (s1_valid[i] && ({1'b0, s1_sel[i]} < OUT_LIMIT)) begin
            if (win_valid[s1_sel[i]]) begin
               losers = losers + 16'd1;
            end else begin
               win_valid[s1_sel[i]] = 1'b1;
               win_data[s1_sel[i]]  = s1_data[i];
            end
         end
      end
      coll_sum = {1'b0, collision_count} + {1'b0, losers};
   end

   // ------------------------------------------------------------------
   // Output register stage
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out_valid  <= '0;
         data_out_data   <= '0;
         collision_count <= 16'd0;
      end else begin
         data_out_valid  <= win_valid;
         data_out_data   <= win_data;
         collision_count <= coll_sum[16] ? 16'hFFFF : coll_sum[15:0];
      end
   end

endmodule

// File: tb/tb_axis_channel_demux.sv
// Bench for axis_channel_demux: directed vectors, reference model feeding an
// expected-beat queue, and a negedge monitor that pops and compares.
module tb_axis_channel_demux;

  localparam int PS  = 16;
  localparam int SW  = 16;
  localparam int CH  = 8;
  localparam int FPC = 1;
  localparam int BC  = 4;
  localparam int NO  = (1 + FPC) * CH;
  localparam int SB  = $clog2(NO);
  localparam int DW  = PS * SW;
  localparam int EW  = 32 + 8 + DW;

  // ---------------- clock / reset / signals ----------------
  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic [CH-1:0][DW-1:0]  din;
  logic [CH-1:0]          din_v;
  logic [NO-1:0][DW-1:0]  dout;
  logic [NO-1:0]          dout_v;
  logic [CH*SB-1:0]       cfg;
  logic                   cfg_v;
  logic                   cfg_r;
  logic [15:0]            coll;
  logic                   st;

  always #5 clk = ~clk;

  axis_channel_demux #(
    .PARALLEL_SAMPLES(PS), .SAMPLE_WIDTH(SW), .CHANNELS(CH),
    .FUNCTIONS_PER_CHANNEL(FPC), .BLANK_CYCLES(BC)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .data_in_data(din), .data_in_valid(din_v),
    .data_out_data(dout), .data_out_valid(dout_v),
    .config_in_data(cfg), .config_in_valid(cfg_v), .config_in_ready(cfg_r),
    .collision_count(coll), .state_dbg(st)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  int               cyc = 0;
  logic [SB-1:0]    m_dest [CH];
  int               m_blank;
  bit               m_armed;
  int               m_count;
  int               m_pend;
  logic [EW-1:0]    exp_q[$];
  bit [NO-1:0]      taken;
  logic [DW-1:0]    w_data [NO];
  int               losers;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CH; i++) m_dest[i] = SB'(i);
      m_blank = 0; m_armed = 0; m_count = 0; m_pend = 0;
      exp_q.delete();
    end else begin
      cyc = cyc + 1;
      m_count = m_pend;
      losers = 0;
      taken = '0;
      if (m_blank == 0) begin
        for (int i = 0; i < CH; i++) begin
          if (din_v[i] === 1'b1 && int'(m_dest[i]) < NO) begin
            if (taken[m_dest[i]]) losers++;
            else begin
              taken[m_dest[i]] = 1'b1;
              w_data[m_dest[i]] = din[i];
            end
          end
        end
      end
      for (int o = 0; o < NO; o++)
        if (taken[o]) exp_q.push_back({32'(cyc + 1), 8'(o), w_data[o]});
      m_pend = (m_count + losers > 65535) ? 65535 : m_count + losers;
      if (m_blank == 0) begin
        if (m_armed && cfg_v) begin
          for (int i = 0; i < CH; i++) m_dest[i] = cfg[SB*i +: SB];
          m_blank = BC;
        end
      end else begin
        m_blank = m_blank - 1;
      end
      m_armed = 1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [DW-1:0] mon_last [NO];
  logic [EW-1:0] got_e;
  logic [EW-1:0] exp_e;
  bit            hold_ok;

  always @(negedge clk) begin
    if (!reset_n) for (int o = 0; o < NO; o++) mon_last[o] = '0;
    check("ready", {63'd0, cfg_r}, {63'd0, (m_armed && m_blank == 0)});
    check("collision_count", {48'd0, coll}, 64'(m_count));
    hold_ok = 1;
    for (int o = 0; o < NO; o++) begin
      if (dout_v[o] === 1'b1) begin
        n_checks++;
        got_e = {32'(cyc), 8'(o), dout[o]};
        if (exp_q.size() == 0) begin
          $display("FAIL beat out%0d cyc %0d: unexpected valid, data %h", o, cyc, dout[o]);
        end else begin
          exp_e = exp_q.pop_front();
          if (got_e === exp_e) n_pass++;
          else $display("FAIL beat out%0d: got cyc %0d out %0d data %h, expected cyc %0d out %0d data %h",
                        o, got_e[EW-1 -: 32], got_e[DW +: 8], got_e[DW-1:0],
                        exp_e[EW-1 -: 32], exp_e[DW +: 8], exp_e[DW-1:0]);
          mon_last[o] = exp_e[DW-1:0];
        end
      end else if (dout[o] !== mon_last[o]) begin
        hold_ok = 0;
        $display("FAIL hold out%0d: got %h expected %h", o, dout[o], mon_last[o]);
      end
    end
    n_checks++;
    if (hold_ok) n_pass++;
  end

  // ---------------- driver tasks ----------------
  task automatic set_beat(input int b);
    for (int i = 0; i < CH; i++) din[i] = {PS{SW'(b * 256 + i * 16 + 5)}};
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cfg_r && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready wait bound", {63'd0, cfg_r}, 64'd1);
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send_cfg(input logic [CH*SB-1:0] c);
    cfg = c;
    cfg_v = 1'b1;
    wait_ready();
    @(negedge clk);
    cfg_v = 1'b0;
  endtask

  logic [31:0] cfgs  [4] = '{32'h7654_3210, 32'h0123_4567, 32'h3333_1111, 32'hFEDC_BA98};
  logic [7:0]  masks [6] = '{8'hFF, 8'h0F, 8'hA5, 8'h81, 8'h3C, 8'h00};
  logic [31:0] cfg_hi;
  int          low;
  int          hits;

  // ---------------- stimulus ----------------
  initial begin
    din = '0; din_v = '0; cfg = '0; cfg_v = 1'b0;
    for (int i = 0; i < CH; i++) cfg_hi[4*i +: 4] = 4'(8 + i);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset ready", {63'd0, cfg_r}, 64'd0);
    check("reset valid", {48'd0, dout_v}, 64'd0);
    check("reset count", {48'd0, coll}, 64'd0);
    check("reset state", {63'd0, st}, 64'd0);
    #2 reset_n = 1'b1;
    #1 check("ready before first edge", {63'd0, cfg_r}, 64'd0);
    @(negedge clk);
    check("ready after first edge", {63'd0, cfg_r}, 64'd1);

    // Identity routing
    set_beat(1);
    din[3] = {PS{16'h1234}};
    din_v = 8'hFF;
    @(negedge clk);
    din_v = '0;
    @(negedge clk);
    check("identity valid", {48'd0, dout_v}, 64'h00FF);
    check("identity out3", dout[3][63:0], 64'h1234_1234_1234_1234);
    @(negedge clk);
    check("valid one cycle", {48'd0, dout_v}, 64'd0);

    // Reconfiguration with continuous input
    set_beat(10);
    din_v = 8'hFF;
    cfg = cfg_hi;
    cfg_v = 1'b1;
    low = 0;
    for (int b = 1; b <= 12; b++) begin
      @(negedge clk);
      cfg_v = 1'b0;
      set_beat(10 + b);
      if (b == 1) check("state blank", {63'd0, st}, 64'd1);
      if (!cfg_r) low++;
    end
    @(negedge clk);
    din_v = '0;
    check("ready low cycles", 64'(low), 64'd4);
    repeat (3) @(negedge clk);

    // Config offered during blanking is held off, then taken intact
    cfg = 32'h7654_3210;
    cfg_v = 1'b1;
    @(negedge clk);
    cfg = 32'h5555_5555;
    check("held off in blank", {63'd0, cfg_r}, 64'd0);
    wait_ready();
    @(negedge clk);
    cfg_v = 1'b0;
    wait_ready();

    // Collision: all inputs to output 5 for 10 beats
    hits = 0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (n < 10) begin
        set_beat(100 + n);
        din_v = 8'hFF;
      end else begin
        din_v = '0;
      end
      if (dout_v === 16'h0020 && dout[5][7:4] === 4'h0) hits++;
    end
    check("out5 ch0 beats", 64'(hits), 64'd10);
    check("collision 70", {48'd0, coll}, 64'd70);

    // Mixed mappings and masks
    for (int c = 0; c < 4; c++) begin
      send_cfg(cfgs[c]);
      wait_ready();
      for (int m = 0; m < 6; m++) begin
        @(negedge clk);
        set_beat(200 + c * 8 + m);
        din_v = masks[m];
      end
      @(negedge clk);
      din_v = '0;
    end
    repeat (3) @(negedge clk);

    // Saturation
    send_cfg(32'h5555_5555);
    wait_ready();
    for (int n = 0; n < 9400; n++) begin
      @(negedge clk);
      set_beat(n);
      din_v = 8'hFF;
    end
    @(negedge clk);
    din_v = '0;
    repeat (3) @(negedge clk);
    check("saturated", {48'd0, coll}, 64'hFFFF);
    @(negedge clk);
    din_v = 8'hFF;
    repeat (3) @(negedge clk);
    din_v = '0;
    repeat (3) @(negedge clk);
    check("saturation hold", {48'd0, coll}, 64'hFFFF);

    // Async reset mid-BLANK with beats in flight
    set_beat(50);
    din_v = 8'hFF;
    cfg = 32'hFEDC_BA98;
    cfg_v = 1'b1;
    @(negedge clk);
    cfg_v = 1'b0;
    set_beat(51);
    @(posedge clk);
    #3 reset_n = 1'b0;
    din_v = '0;
    #1;
    check("async valid clear", {48'd0, dout_v}, 64'd0);
    check("async data clear", dout[5][63:0], 64'd0);
    check("async count clear", {48'd0, coll}, 64'd0);
    check("async ready low", {63'd0, cfg_r}, 64'd0);
    check("async state run", {63'd0, st}, 64'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    #1 check("ready low after release", {63'd0, cfg_r}, 64'd0);
    @(negedge clk);
    check("ready high after edge", {63'd0, cfg_r}, 64'd1);
    set_beat(60);
    din_v = 8'hFF;
    @(negedge clk);
    din_v = '0;
    @(negedge clk);
    check("identity after reset", {48'd0, dout_v}, 64'h00FF);

    // Drain and report
    for (int n = 0; n < 20 && exp_q.size() > 0; n++) @(negedge clk);
    check("queue drained", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
